// File: rtl/mpmc9_strip_sequencer.sv
// mpmc9_strip_sequencer
// Issues the train of app-interface commands for one memory transaction,
// counts accepted commands and returned read strips, tags each returned
// strip with its index and pulses done when the transaction is complete.
module mpmc9_strip_sequencer #(
  parameter int          STRIP_BYTES = 16,
  parameter int          AW          = 32,
  parameter logic [2:0]  CMD_RD      = 3'b001,
  parameter logic [2:0]  CMD_WR      = 3'b000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [5:0]    num_strips,
  input  logic          app_rdy,
  input  logic          app_rd_data_valid,
  output logic          app_en,
  output logic [2:0]    app_cmd,
  output logic [AW-1:0] app_addr,
  output logic [5:0]    strip_num,
  output logic          busy,
  output logic          done
);

  localparam int            OFS        = $clog2(STRIP_BYTES);
  localparam logic [AW-1:0] STEP       = AW'(STRIP_BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << OFS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic       we_lat;
  logic [5:0] ns_lat;
  logic [5:0] cmd_cnt;
  logic [5:0] resp_cnt;

  logic accept;
  logic last_cmd;
  logic resp_active;
  logic final_resp;

  // Handshake and completion conditions shared by the state machine.
  // A write is always a single command, so it is "last" on its first accept.
  always_comb begin
    accept      = app_en & app_rdy;
    last_cmd    = we_lat | (cmd_cnt == ns_lat);
    resp_active = ((state == S_CMD) | (state == S_WAIT)) & app_rd_data_valid;
    final_resp  = resp_active & ~we_lat & (resp_cnt == ns_lat);
  end

  // The returned strip is tagged with the number of strips already received.
  assign strip_num = resp_cnt;

  // Transaction state machine with registered command and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      we_lat   <= 1'b0;
      ns_lat   <= 6'd0;
      cmd_cnt  <= 6'd0;
      resp_cnt <= 6'd0;
      app_en   <= 1'b0;
      app_cmd  <= CMD_RD;
      app_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            we_lat   <= we;
            ns_lat   <= num_strips;
            app_addr <= adr & ALIGN_MASK;
            app_cmd  <= we ? CMD_WR : CMD_RD;
            cmd_cnt  <= 6'd0;
            resp_cnt <= 6'd0;
            app_en   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_CMD;
          end
        end

        S_CMD: begin
          if (accept) begin
            app_addr <= app_addr + STEP;
            if (!last_cmd) begin
              cmd_cnt <= cmd_cnt + 6'd1;
            end
          end
          if (resp_active && !final_resp) begin
            resp_cnt <= resp_cnt + 6'd1;
          end
          if (final_resp) begin
            app_en <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (accept && last_cmd) begin
            app_en <= 1'b0;
            if (we_lat) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (resp_active && !final_resp) begin
            resp_cnt <= resp_cnt + 6'd1;
          end
          if (final_resp) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          app_en <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
